// File: rtl/reg_file_scoreboard.sv
// General-purpose register file with two read ports, one write-back port
// and a per-register pending-write scoreboard for decode hazard stalls.
module reg_file_scoreboard #(
    parameter int WIDTH = 32,
    parameter int REGS  = 16,
    parameter int CNT_W = 2
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic [$clog2(REGS)-1:0]       rs1_addr,
    input  logic [$clog2(REGS)-1:0]       rs2_addr,
    output logic [WIDTH-1:0]              rd1,
    output logic [WIDTH-1:0]              rd2,
    output logic                          rs1_busy,
    output logic                          rs2_busy,
    input  logic                          issue_en,
    input  logic [$clog2(REGS)-1:0]       issue_rd,
    output logic                          issue_ok,
    input  logic                          wb_en,
    input  logic [$clog2(REGS)-1:0]       wb_addr,
    input  logic [WIDTH-1:0]              wb_data,
    output logic                          wb_err,
    output logic [$clog2(REGS)+CNT_W-1:0] inflight
);

    localparam int AW = $clog2(REGS);
    localparam int IW = AW + CNT_W;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [WIDTH-1:0] regs_q [REGS];
    logic [CNT_W-1:0] cnt_q  [REGS];
    logic [CNT_W-1:0] cnt_d  [REGS];
    logic             err_q;
    logic             err_d;
    logic [IW-1:0]    infl_q;
    logic [IW-1:0]    infl_d;

    logic wb_live;
    logic iss_live;
    logic wb_hit1;
    logic wb_hit2;

    assign wb_live = wb_en && (wb_addr != '0);
    assign wb_hit1 = wb_en && (wb_addr == rs1_addr);
    assign wb_hit2 = wb_en && (wb_addr == rs2_addr);

    // Same-cycle write-back is forwarded so decode never reads a stale value.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1_addr != '0) begin
            rd1 = wb_hit1 ? wb_data : regs_q[rs1_addr];
        end
        if (rs2_addr != '0) begin
            rd2 = wb_hit2 ? wb_data : regs_q[rs2_addr];
        end
    end

    // A retiring last write is bypassed, so it no longer stalls the reader.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        if (rs1_addr != '0) begin
            rs1_busy = (cnt_q[rs1_addr] != '0) &&
                       !((cnt_q[rs1_addr] == CNT_W'(1)) && wb_hit1);
        end
        if (rs2_addr != '0) begin
            rs2_busy = (cnt_q[rs2_addr] != '0) &&
                       !((cnt_q[rs2_addr] == CNT_W'(1)) && wb_hit2);
        end
    end

    always_comb begin
        issue_ok = !issue_en
                || (issue_rd == '0)
                || (cnt_q[issue_rd] != CMAX)
                || (wb_en && (wb_addr == issue_rd));
    end

    assign iss_live = issue_en && issue_ok && (issue_rd != '0);

    always_comb begin
        logic inc;
        logic dec;
        infl_d = '0;
        for (int r = 0; r < REGS; r++) begin
            inc = iss_live && (issue_rd == AW'(r));
            dec = wb_live && (wb_addr == AW'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (inc && !dec) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            infl_d = infl_d + IW'(cnt_d[r]);
        end
    end

    always_comb begin
        err_d = err_q;
        if (wb_live && (cnt_q[wb_addr] == '0) &&
            !(iss_live && (issue_rd == wb_addr))) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int r = 0; r < REGS; r++) begin
                regs_q[r] <= '0;
                cnt_q[r]  <= '0;
            end
            err_q  <= 1'b0;
            infl_q <= '0;
        end else begin
            if (wb_live) begin
                regs_q[wb_addr] <= wb_data;
            end
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            infl_q <= infl_d;
        end
    end

    assign wb_err   = err_q;
    assign inflight = infl_q;

endmodule

// File: doc/reg_file_scoreboard.md
Name: reg_file_scoreboard

Overview:
- General-purpose register file for the pipelined CPU: two combinational read ports and one write-back port, with a per-register pending-write scoreboard.
- Decode reads operands here and gets busy flags for hazard stalls.
- Issue marks a destination pending; write-back retires it.
- Write-back bypass through the file: a value written this cycle is visible on reads the same cycle.

Parameters:
- WIDTH, 32, data bits per register
- REGS, 16, number of architectural registers; R0 is hardwired zero
- CNT_W, 2, width of each pending-write counter (max in-flight writes per register = 2^CNT_W - 1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- clear  in  1  reset, synchronous, active-high
- rs1_addr  in  $clog2(REGS)  read port 1 address
- rs2_addr  in  $clog2(REGS)  read port 2 address
- rd1  out  WIDTH  read port 1 data (combinational)
- rd2  out  WIDTH  read port 2 data (combinational)
- rs1_busy  out  1  register rs1_addr has a pending write not yet retired
- rs2_busy  out  1  same for rs2_addr
- issue_en  in  1  instruction with destination issues this cycle
- issue_rd  in  $clog2(REGS)  destination of issuing instruction
- issue_ok  out  1  issue accepted (combinational)
- wb_en  in  1  write-back valid
- wb_addr  in  $clog2(REGS)  write-back destination
- wb_data  in  WIDTH  write-back value
- wb_err  out  1  sticky: write-back to a register with zero pending count
- inflight  out  $clog2(REGS)+CNT_W  total pending writes across all registers

Behaviour:
- Reset (clear=1 at rising edge): all registers 0, all counters 0, wb_err 0, inflight 0. clear overrides issue_en and wb_en in the same cycle.
- Read:
  - rdN = 0 if rsN_addr==0.
  - Otherwise rdN = wb_data if wb_en && wb_addr==rsN_addr (bypass); else the stored value.
  - Zero latency.
- rsN_busy:
  - 0 for R0.
  - Otherwise 1 iff count[rsN_addr] != 0, except it is 0 when count==1 and wb_en && wb_addr==rsN_addr this cycle, since the retiring write is bypassed.
- Write: on the edge with wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data. Writes to R0 are ignored and never touch counters or wb_err.
- Issue:
  - issue_ok = !issue_en || issue_rd==0 || count[issue_rd] != max, where max = 2^CNT_W-1.
  - Same-cycle retirement to issue_rd counts as freeing a slot, so issue_ok is 1 if count==max && wb_en && wb_addr==issue_rd.
  - Issue to R0 is always accepted with no counter change.
- Counter update per register r (r!=0), evaluated each edge:
  - inc = issue_en && issue_ok && issue_rd==r
  - dec = wb_en && wb_addr==r && count[r]!=0
  - inc && dec: unchanged. inc only: +1. dec only: -1. Counters never wrap.
- wb_err:
  - Set when wb_en && wb_addr!=0 && count[wb_addr]==0 && !(issue_en && issue_ok && issue_rd==wb_addr).
  - The data write still occurs.
  - Cleared only by clear.
- inflight:
  - Registered sum of all counters, updated on the same edge as the counters.
  - It equals the counter sum after the edge and never disagrees with the counters.
- Mid-operation clear: all pending state is discarded and the file returns to the reset state. The pipeline is responsible for flushing in-flight instructions together with clear.

Test Plan:
- Reset then read: clear for 1 cycle, rs1=3, rs2=0 -> rd1=0, rd2=0, busy=0, inflight=0, wb_err=0.
- Issue/retire: issue_rd=5 at cycle 1 -> rs1_busy(5)=1 and inflight=1 from cycle 2. wb_en, wb_addr=5, wb_data=0xDEADBEEF at cycle 4 -> same cycle rd1=0xDEADBEEF and busy=0. Cycle 5: stored, inflight=0.
- Saturation: three issues to R7 -> count=3. Fourth issue_en to R7 -> issue_ok=0, count stays 3. Fourth issue with concurrent wb to R7 -> issue_ok=1, count stays 3.
- Simultaneous issue and wb to R2 with count=1 -> count stays 1, reg[2] updated, wb_err=0.
- Stray write-back: wb_en to R9 with count 0 -> reg[9] written and wb_err=1 and stays 1 until clear. wb_en to R0 with data 0x1234 -> rd of R0 = 0, no wb_err.
- Mid-operation clear with R4 pending (count=2) and wb_en asserted the same cycle -> next cycle count=0, reg[4]=0, inflight=0.
